key_sched_ctrl: RTL
===================

KEY_SCHED_CTRL -- requirements
Module: key_sched_ctrl

Interface
REQ-001 The module SHALL have one clock, CLK, and its reset, RST_N, SHALL be asynchronous and active-low.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RST_N  input  1  asynchronous active-low reset.
REQ-004 START  input  1  begin a 16-round key schedule; sampled only in IDLE.
REQ-005 DECRYPT  input  1  sampled with START; 0 = rounds 1..16 ascending, 1 = rounds 16..1 descending.
REQ-006 ABORT  input  1  synchronous cancel of the current schedule.
REQ-007 C_IN  input  56  left key half after PC-1, sampled with START.
REQ-008 D_IN  input  56  right key half after PC-1, sampled with START.
REQ-009 SUBKEY_ACK  input  1  consumer accepts the presented subkey.
REQ-010 C_OUT  output  56  rotated left half for the current round.
REQ-011 D_OUT  output  56  rotated right half for the current round.
REQ-012 ROUND  output  4  current round number minus 1 (0..15).
REQ-013 SUBKEY_VALID  output  1  C_OUT, D_OUT and ROUND are valid.
REQ-014 BUSY  output  1  a schedule is in progress.
REQ-015 DONE  output  1  one-cycle pulse after the last subkey is accepted.

Function
REQ-016 The shift amount sh(r) SHALL be 1 for rounds r = 1, 2, 9 and 16, and 2 for all other rounds.
REQ-017 The cumulative shift S(r) SHALL be the sum of sh(1) through sh(r), so S(16) = 28.
REQ-018 All rotations SHALL be full 56-bit circular rotations applied to each half independently, with no bits lost.
REQ-019 The FSM SHALL have two states: IDLE and PRESENT.
REQ-020 IDLE with START=1, encrypt mode: load C_OUT = rotl(C_IN, 1) and D_OUT = rotl(D_IN, 1), set ROUND = 0, and go to PRESENT.
REQ-021 IDLE with START=1, decrypt mode: load C_OUT = rotl(C_IN, 28) and D_OUT = rotl(D_IN, 28), set ROUND = 15, and go to PRESENT.
REQ-022 Latency SHALL be one cycle: START sampled at edge n gives SUBKEY_VALID=1 after edge n.
REQ-023 In PRESENT, SUBKEY_VALID SHALL be 1 and C_OUT, D_OUT and ROUND SHALL be held stable until SUBKEY_ACK=1 at a clock edge.
REQ-024 On an ACK in encrypt mode that is not the last round: rotate both halves left by sh(r+1) and increment ROUND; SUBKEY_VALID stays 1.
REQ-025 On an ACK in decrypt mode that is not the last round: rotate both halves right by sh(r) and decrement ROUND; SUBKEY_VALID stays 1.
REQ-026 On the last-round ACK (encrypt ROUND=15, decrypt ROUND=0): go to IDLE, SUBKEY_VALID=0, DONE=1 for exactly one cycle, C_OUT and D_OUT hold their last values.
REQ-027 BUSY SHALL equal (state == PRESENT).
REQ-028 START while BUSY=1 SHALL be ignored, and DECRYPT, C_IN and D_IN SHALL be ignored except at the accepted START.
REQ-029 ABORT=1 in PRESENT SHALL return to IDLE at the next edge with SUBKEY_VALID=0 and no DONE pulse.
REQ-030 ABORT SHALL take priority over a simultaneous SUBKEY_ACK, and ABORT in IDLE SHALL take priority over START (START not accepted).
REQ-031 SUBKEY_ACK while SUBKEY_VALID=0 SHALL have no effect.
REQ-032 DONE and a new START SHALL NOT overlap, because START is accepted at the earliest one cycle after DONE is asserted (back-to-back schedules allowed).

Reset
REQ-033 RST_N=0 SHALL immediately force state IDLE, C_OUT=0, D_OUT=0, ROUND=0, SUBKEY_VALID=0, BUSY=0 and DONE=0.
REQ-034 Reset asserted mid-schedule SHALL discard the schedule without a DONE pulse, and the first START after reset release SHALL start from round 1 (or round 16 in decrypt mode).

Verification
REQ-035 Encrypt, C_IN=56'h00000000000001, D_IN=0, ACK held 1 -> C_OUT sequence 56'h...02, ...04, ...10 for ROUND 0, 1, 2; ROUND=15 shows 56'h00000010000000; DONE pulses once; 16 VALID cycles total.
REQ-036 Decrypt, same C_IN -> ROUND=15 with C_OUT=56'h00000010000000, then ROUND=14 with C_OUT=56'h00000008000000, and ROUND=0 ends at C_OUT=56'h00000000000002.
REQ-037 Wrap: encrypt, C_IN=56'h80000000000000 -> round-1 C_OUT=56'h00000000000001.
REQ-038 Backpressure: ACK low for 5 cycles at ROUND=3 -> outputs stable and VALID=1 throughout; advance occurs only on the edge where ACK=1.
REQ-039 ABORT and ACK together at ROUND=7 -> IDLE, VALID=0, no DONE; a START during BUSY is ignored.
REQ-040 RST_N pulsed low at ROUND=9 -> all outputs 0 asynchronously; a new START then gives ROUND=0.

Source files
------------

// File: rtl/key_sched_ctrl.sv
// Key-schedule sequencer: presents 16 rotated C/D half pairs, one per round,
// ascending for encrypt and descending for decrypt, with ready/ack backpressure.
//
// state   | meaning
// IDLE    | no schedule; waits for start (abort wins over start)
// PRESENT | subkey_valid=1, outputs held until subkey_ack, abort or reset
module key_sched_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        decrypt,
    input  logic        abort,
    input  logic [55:0] c_in,
    input  logic [55:0] d_in,
    input  logic        subkey_ack,
    output logic [55:0] c_out,
    output logic [55:0] d_out,
    output logic [3:0]  round,
    output logic        subkey_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [55:0] c_q, c_d, d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic        done_q, done_d;
    logic        last_round;

    function automatic logic [55:0] rotl(input logic [55:0] x, input int unsigned n);
        return (x << n) | (x >> (56 - n));
    endfunction

    // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one, all others by two.
    function automatic logic sh_one(input logic [3:0] idx);
        return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dec_q   <= dec_d;
            done_q  <= done_d;
        end
    end

    assign last_round = dec_q ? (round_q == 4'd0) : (round_q == 4'd15);

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = PRESENT;
                    dec_d   = decrypt;
                    if (decrypt) begin
                        // Decrypt begins at round 16, whose cumulative shift is 28.
                        c_d     = rotl(c_in, 28);
                        d_d     = rotl(d_in, 28);
                        round_d = 4'd15;
                    end else begin
                        c_d     = rotl(c_in, 1);
                        d_d     = rotl(d_in, 1);
                        round_d = 4'd0;
                    end
                end
            end
            PRESENT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (subkey_ack) begin
                    if (last_round) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else if (dec_q) begin
                        // Undo the shift that produced the current round.
                        c_d     = sh_one(round_q) ? rotl(c_q, 55) : rotl(c_q, 54);
                        d_d     = sh_one(round_q) ? rotl(d_q, 55) : rotl(d_q, 54);
                        round_d = round_q - 4'd1;
                    end else begin
                        c_d     = sh_one(round_q + 4'd1) ? rotl(c_q, 1) : rotl(c_q, 2);
                        d_d     = sh_one(round_q + 4'd1) ? rotl(d_q, 1) : rotl(d_q, 2);
                        round_d = round_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        subkey_valid = (state_q == PRESENT);
        busy         = (state_q == PRESENT);
        done         = done_q;
        c_out        = c_q;
        d_out        = d_q;
        round        = round_q;
    end

endmodule
